serial_wholesub: RTL and testbench
==================================

SERIAL_WHOLESUB -- requirements
Module: serial_wholesub

Interface
REQ-001 Parameter N SHALL be declared with default 8 and meaning operand width in bits, legal range N >= 2.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port start  input  1  SHALL request a subtraction; it is sampled on the rising edge of clk.
REQ-005 Port a  input  N  SHALL be the minuend; it is sampled together with start.
REQ-006 Port b  input  N  SHALL be the subtrahend; it is sampled together with start.
REQ-007 Port borrow_in  input  1  SHALL be the incoming borrow; it is sampled together with start.
REQ-008 Port busy  output  1  SHALL be high while the subtraction is in progress.
REQ-009 Port done  output  1  SHALL be a one-cycle pulse marking that the result is valid.
REQ-010 Port diff  output  N  SHALL be the difference, a - b - borrow_in modulo 2^N.
REQ-011 Port borrow_out  output  1  SHALL be the final borrow out of bit N-1.

Function
REQ-012 States SHALL be IDLE, RUN and DONE; an internal bit counter cnt SHALL be ceil(log2(N)) bits wide.
REQ-013 In IDLE or DONE, start=1 at a clock edge SHALL latch a, b and borrow_in, clear cnt to 0 and enter RUN.
REQ-014 In RUN, start SHALL be ignored, and operands latched earlier SHALL NOT change when the inputs change.
REQ-015 Each RUN cycle SHALL process bit i=cnt only: d_i = a_i ^ b_i ^ br, and br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 br SHALL start at the latched borrow_in; d_i SHALL be written into diff[i]; and cnt SHALL increment by 1.
REQ-017 RUN SHALL last exactly N cycles; at the edge that processes bit N-1, the block SHALL set borrow_out to br_next and enter DONE.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-019 Latency: start accepted at edge t, so done is high for the cycle after edge t+N and busy is high for the N cycles before it.
REQ-020 DONE SHALL last one cycle; it SHALL then go to IDLE, or straight to RUN if start=1 on that edge (back-to-back operation).
REQ-021 diff and borrow_out SHALL hold their values from the end of DONE until the next accepted start.
REQ-022 After the next accepted start, diff bits SHALL update one per cycle, LSB first, and SHALL NOT be relied on until done.
REQ-023 The counter SHALL NOT wrap inside RUN; the transition out of RUN SHALL be decoded at cnt==N-1.
REQ-024 a==b with borrow_in=0 SHALL give diff=0 and borrow_out=0.
REQ-025 a==b with borrow_in=1 SHALL give diff = all ones and borrow_out=1.

Reset
REQ-026 rst=1 SHALL, asynchronously and at any time (RUN included), force state=IDLE, cnt=0, busy=0, done=0, diff=0, borrow_out=0 and clear the latched operands and br.
REQ-027 A start asserted while rst=1 SHALL be ignored.
REQ-028 The first start accepted after rst deasserts SHALL behave exactly as in REQ-013.

Verification
REQ-029 N=8, a=5, b=3, borrow_in=0, start pulse -> busy high for 8 cycles, then done for one cycle, with diff=8'h02 and borrow_out=0.
REQ-030 N=8, a=3, b=5, borrow_in=0 -> diff=8'hFE, borrow_out=1; and a=8'h00, b=8'h00, borrow_in=1 -> diff=8'hFF, borrow_out=1.
REQ-031 N=8, start held high continuously, with a=10, b=4 then a=4, b=10 presented at the DONE cycle -> results 8'h06/borrow_out=0 then 8'hFA/borrow_out=1; each result takes 8 RUN cycles and no IDLE cycle appears between them.
REQ-032 N=8, start with a=9, b=1; during RUN, change a and b and pulse start -> start ignored, and the result is still diff=8'h08 with done exactly once.
REQ-033 N=8, rst asserted at the fourth RUN cycle (between clock edges) -> busy, done, diff and borrow_out are all 0 immediately; no done pulse follows; the next start with a=1, b=1 gives diff=0 after 8 cycles.
REQ-034 N=3, exhaustive over all a, b and borrow_in -> every result matches (a - b - borrow_in) mod 8, with borrow_out = (a < b + borrow_in).

Source files
------------

// File: rtl/serial_wholesub.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per cycle, LSB first,
// with a start/busy/done handshake and back-to-back restart from DONE.
//
// state | meaning
// IDLE  | waiting for start; diff/borrow_out hold the last result
// RUN   | processing bit cnt of the latched operands
// DONE  | one-cycle result-valid pulse; start here restarts without an IDLE gap
module serial_wholesub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         borrow_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          br;

  logic a_i;
  logic b_i;
  logic d_i;
  logic br_next;

  always_comb begin
    a_i     = a_q[cnt];
    b_i     = b_q[cnt];
    d_i     = a_i ^ b_i ^ br;
    br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      br         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br    <= borrow_in;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          diff[cnt] <= d_i;
          br        <= br_next;
          // Exit is decoded at the last bit so cnt never wraps inside RUN.
          if (cnt == CW'(N - 1)) begin
            borrow_out <= br_next;
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_wholesub.sv
// Scoreboard bench for serial_wholesub: an N=8 instance driven with directed and
// random operations, and an N=3 instance swept exhaustively.
module tb_serial_wholesub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- N = 8 instance ----------------
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;
  logic [8:0] q8[$];
  logic [8:0] last8 = '0;
  int         cur8 = -100;

  serial_wholesub #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  // ---------------- N = 3 instance ----------------
  logic       start3 = 1'b0, bin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, bo3;
  logic [2:0] diff3;
  logic [3:0] q3[$];
  logic [3:0] last3 = '0;
  int         cur3 = -100;

  serial_wholesub #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .borrow_in(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3)
  );

  // Reference: plain modular arithmetic, {borrow_out, diff}.
  function automatic logic [8:0] ref8(input int a, input int b, input int bin);
    int d;
    d = a - b - bin;
    ref8 = {logic'(a < b + bin), 8'(d & 255)};
  endfunction

  function automatic logic [3:0] ref3(input int a, input int b, input int bin);
    int d;
    d = a - b - bin;
    ref3 = {logic'(a < b + bin), 3'(d & 7)};
  endfunction

  // Monitors: expected timing comes from the accept cycle of the operation in flight.
  always @(negedge clk) begin
    if (!rst) begin
      bit eb, ed;
      logic [8:0] e;
      eb = (cyc >= cur8) && (cyc < cur8 + 8);
      ed = (cyc == cur8 + 8);
      chk("busy8", busy8, eb);
      chk("done8", done8, ed);
      if (done8) begin
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          e = q8.pop_front();
          chk("diff8", diff8, e[7:0]);
          chk("borrow_out8", bo8, e[8]);
          last8 = e;
        end
      end else if (!eb && !ed) begin
        chk("hold8", {bo8, diff8}, last8);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit eb, ed;
      logic [3:0] e;
      eb = (cyc >= cur3) && (cyc < cur3 + 3);
      ed = (cyc == cur3 + 3);
      chk("busy3", busy3, eb);
      chk("done3", done3, ed);
      if (done3) begin
        if (q3.size() == 0) chk("done3_unexpected", 1, 0);
        else begin
          e = q3.pop_front();
          chk("diff3", diff3, e[2:0]);
          chk("borrow_out3", bo3, e[3]);
          last3 = e;
        end
      end else if (!eb && !ed) begin
        chk("hold3", {bo3, diff3}, last3);
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    @(posedge clk); #1;
    cur8 = cyc;
    q8.push_back(ref8(a, b, bin));
    start8 = 1'b0;
  endtask

  task automatic wait8();
    int n = 0;
    while (q8.size() != 0 && n < 40) begin
      @(posedge clk); n++;
    end
    if (q8.size() != 0) begin
      chk("timeout8", 0, 1);
      q8.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic bin);
    int n = 0;
    @(negedge clk);
    start3 = 1'b1; a3 = a; b3 = b; bin3 = bin;
    @(posedge clk); #1;
    cur3 = cyc;
    q3.push_back(ref3(a, b, bin));
    start3 = 1'b0;
    while (q3.size() != 0 && n < 20) begin
      @(posedge clk); n++;
    end
    if (q3.size() != 0) begin
      chk("timeout3", 0, 1);
      q3.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_borrow", bo8, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    op8(8'd5, 8'd3, 1'b0);   wait8();
    op8(8'd3, 8'd5, 1'b0);   wait8();
    op8(8'h00, 8'h00, 1'b1); wait8();
    op8(8'h5A, 8'h5A, 1'b0); wait8();
    op8(8'hC3, 8'hC3, 1'b1); wait8();

    // Start held high; second operands presented during the DONE cycle.
    op8(8'd10, 8'd4, 1'b0);
    start8 = 1'b1;
    repeat (8) @(posedge clk);
    #1; a8 = 8'd4; b8 = 8'd10;
    @(posedge clk); #1;
    chk("b2b_accept_cycle", cyc, cur8 + 9);
    cur8 = cyc;
    q8.push_back(ref8(4, 10, 0));
    start8 = 1'b0;
    wait8();

    // Input changes and a start pulse during RUN must not disturb the operation.
    op8(8'd9, 8'd1, 1'b0);
    @(negedge clk); a8 = 8'hAA; b8 = 8'h33; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); a8 = 8'h11; b8 = 8'hEE;
    wait8();

    // Async reset in the fourth RUN cycle.
    op8(8'd200, 8'd7, 1'b1);
    repeat (3) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_diff", diff8, 0);
    chk("mid_rst_borrow", bo8, 0);
    cur8 = -100; q8.delete(); last8 = '0;
    cur3 = -100; q3.delete(); last3 = '0;
    @(negedge clk); start8 = 1'b1; a8 = 8'd50; b8 = 8'd1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    op8(8'd1, 8'd1, 1'b0); wait8();

    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
      wait8();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          op3(3'(a), 3'(b), 1'(c));
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
    $fatal(1, "global timeout");
  end

endmodule
